uart_echo_fifo: RTL and testbench
=================================

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two between 2 and 256.
REQ-002 The module SHALL have parameter TIMEOUT, default 2048, meaning the maximum hwclk cycles spent in WAIT_DONE.
REQ-003 Port hwclk  input  1  the 12 MHz system clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n  input  1  the reset, which SHALL be asynchronous and active-low.
REQ-005 Port i_Rx_DV  input  1  one-cycle pulse from the receiver marking i_Rx_Byte valid.
REQ-006 Port i_Rx_Byte  input  8  received byte.
REQ-007 Port i_Tx_Active  input  1  transmitter busy.
REQ-008 Port i_Tx_Done  input  1  one-cycle pulse from the transmitter at end of frame.
REQ-009 Port o_Tx_DV  output  1  one-cycle start request to the transmitter.
REQ-010 Port o_Tx_Byte  output  8  byte to transmit; it SHALL be stable from the o_Tx_DV cycle until the next o_Tx_DV.
REQ-011 Port o_Count  output  log2(DEPTH)+1  FIFO occupancy.
REQ-012 Port o_Empty  output  1  o_Count == 0.
REQ-013 Port o_Full  output  1  o_Count == DEPTH.
REQ-014 Port o_Overflow  output  1  sticky flag for a dropped byte.
REQ-015 Port o_Timeout  output  1  sticky flag for a missing i_Tx_Done.

Function
REQ-016 The module SHALL be fully synchronous to hwclk, with all outputs registered except o_Empty and o_Full, which SHALL decode o_Count.
REQ-017 Push: an i_Rx_DV high at an edge while not full SHALL write i_Rx_Byte at wr_ptr, advance wr_ptr modulo DEPTH, and increment o_Count at that edge.
REQ-018 Push while full without a same-edge pop SHALL be discarded, SHALL leave storage and pointers unchanged, and SHALL set o_Overflow.
REQ-019 A push and a pop at the same edge SHALL both occur, leaving o_Count unchanged; this SHALL also hold when full.
REQ-020 The FSM SHALL have exactly the states IDLE, WAIT_DONE, and GAP.
REQ-021 IDLE: at an edge where o_Count > 0 and i_Tx_Active == 0, the FSM SHALL load o_Tx_Byte with mem[rd_ptr], set o_Tx_DV = 1, advance rd_ptr modulo DEPTH, decrement o_Count (pop), and go to WAIT_DONE.
REQ-022 o_Tx_DV SHALL be high for exactly one cycle per popped byte and SHALL never be high outside the cycle following an IDLE pop.
REQ-023 WAIT_DONE: i_Tx_Done SHALL cause a transition to GAP.
REQ-024 WAIT_DONE: reaching a cycle count of TIMEOUT without i_Tx_Done SHALL set o_Timeout and cause a transition to GAP.
REQ-025 The WAIT_DONE cycle counter SHALL clear on entry to WAIT_DONE.
REQ-026 GAP SHALL last one cycle and then return to IDLE, giving the transmitter one clear cycle before the next o_Tx_DV.
REQ-027 Latency: i_Rx_DV at edge k into an empty FIFO with an idle transmitter SHALL produce o_Tx_DV high between edges k+1 and k+2.
REQ-028 The FSM SHALL ignore i_Tx_Done outside WAIT_DONE.
REQ-029 i_Tx_Done and i_Rx_DV at the same edge SHALL both be honoured.
REQ-030 Pointers SHALL wrap from DEPTH-1 to 0 with no gap in data ordering, so output order equals input order.
REQ-031 o_Overflow and o_Timeout SHALL clear only on reset.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, pointers 0, o_Count 0, o_Tx_DV 0, o_Tx_Byte 8'h00, o_Overflow 0, o_Timeout 0, and the timeout counter 0.
REQ-033 Reset asserted mid-transfer (in WAIT_DONE) SHALL discard all queued bytes.
REQ-034 Storage contents SHALL need no reset.
REQ-035 Release of rst_n SHALL be treated as synchronous to hwclk by the integrator; no pop SHALL occur at the first edge after release.

Verification
REQ-036 Single byte: push 8'h41 with transmitter idle -> o_Tx_DV pulse with o_Tx_Byte = 8'h41 one edge after the push; o_Count 1 -> 0; state WAIT_DONE until an i_Tx_Done pulse, then GAP, then IDLE.
REQ-037 Burst/order: push 8'h00..8'h13 (20 bytes, DEPTH 16) back-to-back while i_Tx_Active = 1 -> o_Full after 16 pushes, o_Overflow = 1, bytes 8'h10..8'h13 dropped; after the transmitter is released the output sequence is 8'h00..8'h0F exactly.
REQ-038 Simultaneous full push/pop: FIFO full; i_Rx_DV high at the same edge an IDLE pop occurs -> o_Count stays 16, o_Overflow stays 0, new byte emitted last.
REQ-039 Timeout: pop with i_Tx_Done never pulsed -> o_Timeout = 1 at cycle TIMEOUT after entering WAIT_DONE, then GAP and IDLE; the next queued byte is then sent.
REQ-040 Wrap-around: 40 single bytes pushed and drained one at a time -> every byte echoed unchanged, pointers wrap twice, o_Empty = 1 at end.
REQ-041 Reset mid-operation: assert rst_n low in WAIT_DONE with o_Count = 5 -> all outputs at reset values without waiting for a clock edge; no o_Tx_DV after release until a new push.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// UART echo buffer: bytes from the receiver are queued in a small FIFO and
// handed to the transmitter one at a time. After each start request the FSM
// waits for the end-of-frame pulse, or gives up after TIMEOUT cycles, then
// idles for one cycle before issuing the next request.
module uart_echo_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic                       hwclk,
  input  logic                       rst_n,
  input  logic                       i_Rx_DV,
  input  logic [7:0]                 i_Rx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic                       o_Tx_DV,
  output logic [7:0]                 o_Tx_Byte,
  output logic [$clog2(DEPTH):0]     o_Count,
  output logic                       o_Empty,
  output logic                       o_Full,
  output logic                       o_Overflow,
  output logic                       o_Timeout
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitDone,
    StGap
  } state_e;

  // Storage is never reset; only the pointers and count define its validity.
  logic [7:0]       mem_q [DEPTH];

  state_e           state_q,    state_d;
  logic [AddrW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CntW-1:0]  count_q,    count_d;
  logic             tx_dv_q,    tx_dv_d;
  logic [7:0]       tx_byte_q,  tx_byte_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q,  timeout_d;
  logic [TmoW-1:0]  tmo_cnt_q,  tmo_cnt_d;

  logic             full;
  logic             empty;
  logic             pop;
  logic             push;

  // Occupancy decode and the push/pop qualifiers shared by all next-state logic.
  always_comb begin
    full  = (count_q == CntW'(DEPTH));
    empty = (count_q == '0);
    pop   = (state_q == StIdle) && !empty && !i_Tx_Active;
    // A same-edge pop frees the slot being written, so a full FIFO still accepts.
    push  = i_Rx_DV && (!full || pop);
  end

  // Next-state for the FIFO bookkeeping, the transmit handshake and the FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    tmo_cnt_d  = '0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AddrW'(1);
      tx_dv_d   = 1'b1;
      tx_byte_d = mem_q[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (i_Rx_DV && !push) begin
      overflow_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (i_Tx_Done) begin
          state_d = StGap;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
          // The TIMEOUT-th cycle in WAIT_DONE is the last one.
          timeout_d = 1'b1;
          state_d   = StGap;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // FIFO storage write; a same-edge pop reads the old entry before it is replaced.
  always_ff @(posedge hwclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Rx_Byte;
    end
  end

  // Output drive; only the empty/full flags are decoded rather than registered.
  always_comb begin
    o_Tx_DV    = tx_dv_q;
    o_Tx_Byte  = tx_byte_q;
    o_Count    = count_q;
    o_Empty    = empty;
    o_Full     = full;
    o_Overflow = overflow_q;
    o_Timeout  = timeout_q;
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: single byte, burst with overflow,
// full push/pop, timeout, pointer wrap and reset in mid-transfer.
module tb_uart_echo_fifo;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CntW    = $clog2(DEPTH) + 1;

  logic            hwclk = 1'b0;
  logic            rst_n;
  logic            i_Rx_DV;
  logic [7:0]      i_Rx_Byte;
  logic            i_Tx_Active;
  logic            i_Tx_Done;
  logic            o_Tx_DV;
  logic [7:0]      o_Tx_Byte;
  logic [CntW-1:0] o_Count;
  logic            o_Empty;
  logic            o_Full;
  logic            o_Overflow;
  logic            o_Timeout;

  int checks = 0;
  int errors = 0;

  uart_echo_fifo #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .hwclk       (hwclk),
    .rst_n       (rst_n),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_Count     (o_Count),
    .o_Empty     (o_Empty),
    .o_Full      (o_Full),
    .o_Overflow  (o_Overflow),
    .o_Timeout   (o_Timeout)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling or changing inputs.
  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dv"},    32'(o_Tx_DV),    32'd0);
    chk({tag, "_byte"},  32'(o_Tx_Byte),  32'h00);
    chk({tag, "_count"}, 32'(o_Count),    32'd0);
    chk({tag, "_empty"}, 32'(o_Empty),    32'd1);
    chk({tag, "_full"},  32'(o_Full),     32'd0);
    chk({tag, "_ovf"},   32'(o_Overflow), 32'd0);
    chk({tag, "_tmo"},   32'(o_Timeout),  32'd0);
  endtask

  task automatic push_one(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    step();
    i_Rx_DV   = 1'b0;
  endtask

  // Done pulse moves WAIT_DONE -> GAP, next edge GAP -> IDLE; byte must hold.
  task automatic finish_tx(input logic [7:0] b);
    i_Tx_Done = 1'b1;
    step();
    i_Tx_Done = 1'b0;
    chk("fin_dv_gap",   32'(o_Tx_DV),   32'd0);
    chk("fin_byte_gap", 32'(o_Tx_Byte), 32'(b));
    step();
    chk("fin_dv_idle",  32'(o_Tx_DV),   32'd0);
    chk("fin_byte_idle", 32'(o_Tx_Byte), 32'(b));
  endtask

  // From IDLE with data queued: the next edge must pop the expected byte.
  task automatic drain_one(input logic [7:0] b);
    step();
    chk("drain_dv",   32'(o_Tx_DV),   32'd1);
    chk("drain_byte", 32'(o_Tx_Byte), 32'(b));
    finish_tx(b);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    i_Rx_DV     = 1'b0;
    i_Rx_Byte   = 8'h00;
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b0;

    // Reset state
    #3;
    chk_reset_vals("rst0");
    step();
    step();
    rst_n = 1'b1;

    // Single byte: pop one edge after push, WAIT_DONE holds further pops
    push_one(8'h41);
    chk("sb_count1", 32'(o_Count), 32'd1);
    chk("sb_dv0",    32'(o_Tx_DV), 32'd0);
    chk("sb_empty0", 32'(o_Empty), 32'd0);
    step();
    chk("sb_dv1",    32'(o_Tx_DV),   32'd1);
    chk("sb_byte",   32'(o_Tx_Byte), 32'h41);
    chk("sb_count0", 32'(o_Count),   32'd0);
    chk("sb_empty1", 32'(o_Empty),   32'd1);
    step();
    chk("sb_dv_one", 32'(o_Tx_DV),   32'd0);
    push_one(8'h42);
    repeat (3) step();
    chk("wd_hold_count", 32'(o_Count), 32'd1);
    chk("wd_hold_dv",    32'(o_Tx_DV), 32'd0);
    // Done and a push on the same edge are both honoured
    i_Tx_Done = 1'b1;
    push_one(8'h43);
    i_Tx_Done = 1'b0;
    chk("dr_count2", 32'(o_Count), 32'd2);
    step();
    chk("gap_dv0",   32'(o_Tx_DV), 32'd0);
    step();
    chk("gap_pop_dv",   32'(o_Tx_DV),   32'd1);
    chk("gap_pop_byte", 32'(o_Tx_Byte), 32'h42);
    chk("gap_pop_cnt",  32'(o_Count),   32'd1);
    finish_tx(8'h42);
    drain_one(8'h43);
    // Done outside WAIT_DONE is ignored
    i_Tx_Done = 1'b1;
    step();
    i_Tx_Done = 1'b0;
    chk("idle_done_dv", 32'(o_Tx_DV), 32'd0);

    // Burst of 20 with transmitter busy: 16 kept, 4 dropped
    i_Tx_Active = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_one(8'(i));
      if (i == 15) begin
        chk("bu_full16", 32'(o_Full),     32'd1);
        chk("bu_cnt16",  32'(o_Count),    32'd16);
        chk("bu_ovf0",   32'(o_Overflow), 32'd0);
      end
    end
    chk("bu_ovf1",   32'(o_Overflow), 32'd1);
    chk("bu_cnt_hold", 32'(o_Count),  32'd16);
    chk("bu_dv_busy", 32'(o_Tx_DV),   32'd0);
    i_Tx_Active = 1'b0;
    for (int i = 0; i < 16; i++) drain_one(8'(i));
    chk("bu_empty", 32'(o_Empty),    32'd1);
    chk("bu_ovf_sticky", 32'(o_Overflow), 32'd1);

    // Reset clears sticky overflow
    rst_n = 1'b0;
    #2;
    chk_reset_vals("rst1");
    step();
    rst_n = 1'b1;

    // Full FIFO: push and pop on the same edge
    i_Tx_Active = 1'b1;
    for (int i = 0; i < 16; i++) push_one(8'(8'h20 + i));
    chk("fp_full", 32'(o_Full), 32'd1);
    i_Tx_Active = 1'b0;
    push_one(8'h30);
    chk("fp_cnt16", 32'(o_Count),    32'd16);
    chk("fp_ovf0",  32'(o_Overflow), 32'd0);
    chk("fp_dv",    32'(o_Tx_DV),    32'd1);
    chk("fp_byte",  32'(o_Tx_Byte),  32'h20);
    finish_tx(8'h20);
    for (int i = 1; i < 17; i++) drain_one(8'(8'h20 + i));
    chk("fp_empty", 32'(o_Empty),    32'd1);
    chk("fp_ovf_end", 32'(o_Overflow), 32'd0);

    // Timeout: no done pulse, give up after TIMEOUT cycles in WAIT_DONE
    push_one(8'h55);
    push_one(8'h66);
    chk("to_pop_dv",   32'(o_Tx_DV),   32'd1);
    chk("to_pop_byte", 32'(o_Tx_Byte), 32'h55);
    chk("to_cnt1",     32'(o_Count),   32'd1);
    repeat (TIMEOUT - 1) step();
    chk("to_early_tmo", 32'(o_Timeout), 32'd0);
    chk("to_early_dv",  32'(o_Tx_DV),   32'd0);
    step();
    chk("to_tmo1",  32'(o_Timeout), 32'd1);
    step();
    chk("to_gap_dv", 32'(o_Tx_DV),  32'd0);
    step();
    chk("to_next_dv",   32'(o_Tx_DV),   32'd1);
    chk("to_next_byte", 32'(o_Tx_Byte), 32'h66);
    finish_tx(8'h66);

    // Wrap-around: 40 single bytes through
    for (int i = 0; i < 40; i++) begin
      push_one(8'(8'hA5 ^ (i * 7)));
      drain_one(8'(8'hA5 ^ (i * 7)));
    end
    chk("wr_empty",   32'(o_Empty),   32'd1);
    chk("wr_tmo_sticky", 32'(o_Timeout), 32'd1);

    // Reset in WAIT_DONE with five bytes queued
    for (int i = 0; i < 6; i++) begin
      i_Rx_DV   = 1'b1;
      i_Rx_Byte = 8'(8'h81 + i);
      step();
    end
    i_Rx_DV = 1'b0;
    chk("rm_cnt5", 32'(o_Count),   32'd5);
    chk("rm_byte", 32'(o_Tx_Byte), 32'h81);
    rst_n = 1'b0;
    #2;
    chk_reset_vals("rst2");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rm_no_dv",  32'(o_Tx_DV), 32'd0);
      chk("rm_no_cnt", 32'(o_Count), 32'd0);
    end
    push_one(8'h77);
    drain_one(8'h77);
    chk("rm_end_empty", 32'(o_Empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
